// File: rtl/nubus_master_seq.sv
// nubus_master_seq
//
// Card-side NuBus master transaction sequencer. It takes one single-word
// request from card logic and runs it on NuBus: arbitration, address cycle,
// data cycle and ACK/status decode. It rearbitrates on try-again-later ACKs
// and aborts the data cycle after TIMEOUT clocks without ACK. The cycle
// strobes go to nubus_misc, which gates the transceivers and the address
// register.
//
// Parameters
//   ARB_CYCLES  clocks arbitration is held before grant is sampled (>=1)
//   TIMEOUT     data-cycle clocks without ACK before abort with status 10
//   RETRY_MAX   try-again-later retries before status 11 (0 = no retry)
//
// Ports
//   clk, reset             NuBus clock; asynchronous active-high reset
//   mem_valid, mem_write   request from card logic (write sampled on accept)
//   mem_ready, mem_status  one-clock completion pulse and its status
//                          (00 ok, 01 error, 10 timeout, 11 retries exhausted)
//   arb_grant, bus_idle    arbitration result and bus-free indication
//   nub_ackn, nub_tmn      NuBus /ACK and /TM1,/TM0 (active-low)
//   nub_rqstn, nub_startn  NuBus /RQST and /START (active-low)
//   master, arbcy, adrcy, dtacy, mtm1n
//                          cycle strobes and write/read direction to nubus_misc
module nubus_master_seq #(
    parameter int ARB_CYCLES = 2,
    parameter int TIMEOUT    = 255,
    parameter int RETRY_MAX  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mem_valid,
    input  logic       mem_write,
    output logic       mem_ready,
    output logic [1:0] mem_status,
    input  logic       arb_grant,
    input  logic       bus_idle,
    input  logic       nub_ackn,
    input  logic [1:0] nub_tmn,
    output logic       nub_rqstn,
    output logic       nub_startn,
    output logic       master,
    output logic       arbcy,
    output logic       adrcy,
    output logic       dtacy,
    output logic       mtm1n
);

    localparam int AW = $clog2(ARB_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    localparam logic [AW-1:0] ARB_LAST  = AW'(ARB_CYCLES);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ADDR,
        DATA,
        DONE
    } state_t;

    state_t        state;
    logic [AW-1:0] arb_cnt;
    logic [TW-1:0] to_cnt;
    logic [RW-1:0] retry_cnt;

    logic [1:0]    st;
    logic [1:0]    ack_status;
    logic          retry_ok;
    logic [AW-1:0] arb_nxt;

    // Status lines are active-low on the bus.
    assign st = ~nub_tmn;

    // 00 ok, 11 try-again-later (reported as 11 once retries run out),
    // anything else is a bus error.
    assign ack_status = (st == 2'b00) ? 2'b00 :
                        (st == 2'b11) ? 2'b11 : 2'b01;

    assign retry_ok = (st == 2'b11) && (retry_cnt < RETRY_LIM);

    // Arbitration count after this clock; it saturates at ARB_LAST so that a
    // granted-but-busy bus keeps re-checking every clock.
    assign arb_nxt = (arb_cnt == ARB_LAST) ? arb_cnt : arb_cnt + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            arb_cnt    <= '0;
            to_cnt     <= '0;
            retry_cnt  <= '0;
            mem_ready  <= 1'b0;
            mem_status <= 2'b00;
            nub_rqstn  <= 1'b1;
            nub_startn <= 1'b1;
            master     <= 1'b0;
            arbcy      <= 1'b0;
            adrcy      <= 1'b0;
            dtacy      <= 1'b0;
            mtm1n      <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mem_valid) begin
                        state     <= ARB;
                        mtm1n     <= mem_write;
                        retry_cnt <= '0;
                        arb_cnt   <= '0;
                        master    <= 1'b1;
                        arbcy     <= 1'b1;
                        nub_rqstn <= 1'b0;
                    end
                end

                ARB: begin
                    if (arb_nxt == ARB_LAST) begin
                        if (arb_grant && bus_idle) begin
                            state      <= ADDR;
                            arb_cnt    <= '0;
                            arbcy      <= 1'b0;
                            adrcy      <= 1'b1;
                            nub_rqstn  <= 1'b1;
                            nub_startn <= 1'b0;
                        end else if (arb_grant) begin
                            // Won, but another master still owns the bus.
                            arb_cnt <= ARB_LAST;
                        end else begin
                            // Lost: restart the arbitration window.
                            arb_cnt <= '0;
                        end
                    end else begin
                        arb_cnt <= arb_nxt;
                    end
                end

                ADDR: begin
                    state      <= DATA;
                    to_cnt     <= '0;
                    adrcy      <= 1'b0;
                    nub_startn <= 1'b1;
                    dtacy      <= 1'b1;
                end

                DATA: begin
                    // ACK takes priority over the timeout in the same clock.
                    if (!nub_ackn && retry_ok) begin
                        state     <= ARB;
                        retry_cnt <= retry_cnt + 1'b1;
                        arb_cnt   <= '0;
                        dtacy     <= 1'b0;
                        arbcy     <= 1'b1;
                        nub_rqstn <= 1'b0;
                    end else if (!nub_ackn || (to_cnt == TO_LAST)) begin
                        state      <= DONE;
                        dtacy      <= 1'b0;
                        master     <= 1'b0;
                        mem_ready  <= 1'b1;
                        mem_status <= nub_ackn ? 2'b10 : ack_status;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nubus_master_seq.sv
// tb_nubus_master_seq
//
// Directed bench for nubus_master_seq with default parameters
// (ARB_CYCLES=2, TIMEOUT=255, RETRY_MAX=3). A responder process plays the
// slave: it drives /ACK a programmed number of data clocks after dtacy rises,
// with the status taken from a short per-transaction sequence.
module tb_nubus_master_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       mem_valid;
    logic       mem_write;
    logic       mem_ready;
    logic [1:0] mem_status;
    logic       arb_grant;
    logic       bus_idle;
    logic       nub_ackn;
    logic [1:0] nub_tmn;
    logic       nub_rqstn;
    logic       nub_startn;
    logic       master;
    logic       arbcy;
    logic       adrcy;
    logic       dtacy;
    logic       mtm1n;

    int checks = 0;
    int errors = 0;
    int excl_bad = 0;

    // Responder controls (written by the main process only).
    logic       ack_en;
    int         ack_delay;
    logic [1:0] st_seq [8];

    nubus_master_seq dut (
        .clk        (clk),
        .reset      (reset),
        .mem_valid  (mem_valid),
        .mem_write  (mem_write),
        .mem_ready  (mem_ready),
        .mem_status (mem_status),
        .arb_grant  (arb_grant),
        .bus_idle   (bus_idle),
        .nub_ackn   (nub_ackn),
        .nub_tmn    (nub_tmn),
        .nub_rqstn  (nub_rqstn),
        .nub_startn (nub_startn),
        .master     (master),
        .arbcy      (arbcy),
        .adrcy      (adrcy),
        .dtacy      (dtacy),
        .mtm1n      (mtm1n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slave model: ACK after ack_delay data clocks, status from st_seq.
    initial begin : responder
        int dcnt;
        int idx;
        dcnt     = 0;
        idx      = 0;
        nub_ackn = 1'b1;
        nub_tmn  = 2'b11;
        forever begin
            @(posedge clk);
            #1;
            if (!master) idx = 0;
            if (dtacy) begin
                if (ack_en && dcnt == ack_delay) begin
                    nub_ackn = 1'b0;
                    nub_tmn  = ~st_seq[idx % 8];
                    idx++;
                end else begin
                    nub_ackn = 1'b1;
                    nub_tmn  = 2'b11;
                end
                dcnt++;
            end else begin
                nub_ackn = 1'b1;
                nub_tmn  = 2'b11;
                dcnt     = 0;
            end
        end
    end

    // Holds mem_valid until mem_ready, counting the clocks spent in each
    // cycle type. n counts edges from request to the mem_ready clock.
    task automatic run_txn(input int maxc, output int n, output int na, output int nadr,
                           output int nd, output logic [1:0] stat, output logic seen);
        n = 0; na = 0; nadr = 0; nd = 0; stat = 2'b00; seen = 1'b0;
        while (!seen && n < maxc) begin
            tick();
            n++;
            if (mem_ready) begin
                seen      = 1'b1;
                stat      = mem_status;
                mem_valid = 1'b0;
            end else begin
                na   += int'(arbcy);
                nadr += int'(adrcy);
                nd   += int'(dtacy);
                if (int'(arbcy) + int'(adrcy) + int'(dtacy) > 1) excl_bad++;
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_master"}, master, 1'b0);
        chk({tag, "_strobes"}, {arbcy, adrcy, dtacy}, 3'b000);
        chk({tag, "_rqst_start"}, {nub_rqstn, nub_startn}, 2'b11);
        chk({tag, "_ready"}, mem_ready, 1'b0);
    endtask

    initial begin : main
        int n, na, nadr, nd, rdy;
        logic [1:0] stat;
        logic seen;

        reset = 1'b1; mem_valid = 1'b0; mem_write = 1'b0;
        arb_grant = 1'b1; bus_idle = 1'b1;
        ack_en = 1'b1; ack_delay = 0;
        for (int i = 0; i < 8; i++) st_seq[i] = 2'b00;

        // Reset state
        tick(); tick();
        chk("rst_outputs", {master, arbcy, adrcy, dtacy, mtm1n, mem_ready}, 6'b0);
        chk("rst_status", mem_status, 2'b00);
        chk("rst_rqst_start", {nub_rqstn, nub_startn}, 2'b11);
        reset = 1'b0;
        tick();

        // Write, uncontested, ACK ok on first data clock
        mem_valid = 1'b1; mem_write = 1'b1;
        run_txn(20, n, na, nadr, nd, stat, seen);
        chk("wr_seen", seen, 1'b1);
        chk("wr_latency", n, 5);
        chk("wr_arb_clks", na, 2);
        chk("wr_adr_clks", nadr, 1);
        chk("wr_dta_clks", nd, 1);
        chk("wr_status", stat, 2'b00);
        chk("wr_mtm1n", mtm1n, 1'b1);
        chk("wr_master_done", master, 1'b0);
        tick();
        check_idle_outputs("wr_after");

        // Read, grant low for three clocks then high
        arb_grant = 1'b0; mem_write = 1'b0; mem_valid = 1'b1;
        tick();
        chk("rd_arb_entry", {arbcy, master, nub_rqstn}, 3'b110);
        chk("rd_mtm1n", mtm1n, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rd_arb_hold", {arbcy, adrcy}, 2'b10);
        end
        arb_grant = 1'b1;
        tick();
        chk("rd_addr", {arbcy, adrcy, nub_startn, nub_rqstn, master}, 5'b01011);
        run_txn(20, n, na, nadr, nd, stat, seen);
        chk("rd_seen", seen, 1'b1);
        chk("rd_tail_latency", n, 2);
        chk("rd_status", stat, 2'b00);
        tick();

        // Granted but bus busy: hold, then address the clock after bus frees
        bus_idle = 1'b0; mem_write = 1'b1; mem_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("busy_arb_hold", {arbcy, adrcy}, 2'b10);
        end
        bus_idle = 1'b1;
        tick();
        chk("busy_addr", {arbcy, adrcy}, 2'b01);
        run_txn(20, n, na, nadr, nd, stat, seen);
        chk("busy_status", {seen, stat}, 3'b100);
        tick();

        // No ACK: timeout after 255 data clocks
        ack_en = 1'b0; mem_valid = 1'b1;
        run_txn(400, n, na, nadr, nd, stat, seen);
        chk("to_seen", seen, 1'b1);
        chk("to_dta_clks", nd, 255);
        chk("to_latency", n, 259);
        chk("to_status", stat, 2'b10);
        tick();
        check_idle_outputs("to_after");

        // ACK (error status) on the last timeout clock wins over timeout
        ack_en = 1'b1; ack_delay = 254; st_seq[0] = 2'b01; mem_valid = 1'b1;
        run_txn(400, n, na, nadr, nd, stat, seen);
        chk("tolast_dta_clks", nd, 255);
        chk("tolast_status", {seen, stat}, 3'b101);
        tick();

        // Try-again-later four times: three rearbitrations, then status 11
        ack_delay = 0;
        for (int i = 0; i < 4; i++) st_seq[i] = 2'b11;
        mem_valid = 1'b1;
        run_txn(60, n, na, nadr, nd, stat, seen);
        chk("rty_arb_clks", na, 8);
        chk("rty_adr_clks", nadr, 4);
        chk("rty_dta_clks", nd, 4);
        chk("rty_latency", n, 17);
        chk("rty_status", {seen, stat}, 3'b111);
        tick();

        // One try-again then ok
        st_seq[0] = 2'b11; st_seq[1] = 2'b00;
        mem_valid = 1'b1;
        run_txn(60, n, na, nadr, nd, stat, seen);
        chk("rty1_arb_clks", na, 4);
        chk("rty1_status", {seen, stat}, 3'b100);
        tick();

        // Error status 10 on read, then request held through DONE
        st_seq[0] = 2'b10; mem_write = 1'b0; mem_valid = 1'b1;
        run_txn(20, n, na, nadr, nd, stat, seen);
        chk("err_status", {seen, stat}, 3'b101);
        mem_valid = 1'b1;
        st_seq[0] = 2'b00;
        tick();
        chk("b2b_idle_gap", {arbcy, master, mem_ready}, 3'b000);
        tick();
        chk("b2b_accept", {arbcy, master}, 2'b11);
        run_txn(20, n, na, nadr, nd, stat, seen);
        chk("b2b_status", {seen, stat}, 3'b100);
        chk("b2b_tail_latency", n, 4);
        chk("excl_strobes", excl_bad, 0);
        tick();

        // Reset in the middle of a data cycle
        ack_en = 1'b0; mem_write = 1'b1; mem_valid = 1'b1;
        n = 0;
        while (!dtacy && n < 10) begin
            tick();
            n++;
        end
        chk("rstd_reached_data", dtacy, 1'b1);
        tick(); tick();
        #2;
        reset = 1'b1;
        #1;
        chk("rstd_async", {master, arbcy, adrcy, dtacy, mtm1n, mem_ready}, 6'b0);
        chk("rstd_rqst_start", {nub_rqstn, nub_startn}, 2'b11);
        chk("rstd_status", mem_status, 2'b00);
        mem_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        rdy = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (mem_ready || master) rdy++;
        end
        chk("rstd_no_ready", rdy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
